// File: rtl/stock_code_lookup_if.sv
// ---------------------------------------------------------------------------
// stock_code_lookup_if
// Host-side bundle for the stock-code lookup engine: the lookup handshake
// (request/ready/done with result) and the host table-write handshake
// (request held until a one-cycle ack).
//   master : order parser / host side (drives requests, receives results)
//   slave  : lookup engine side
// ---------------------------------------------------------------------------
interface stock_code_lookup_if #(
  parameter int CODE_W = 48,
  parameter int DATA_W = 21,
  parameter int ADDR_W = 9
);
  // Lookup handshake
  logic                     lookup_req;
  logic [CODE_W-1:0]        lookup_code;
  logic                     lookup_ready;
  logic                     lookup_done;
  logic                     lookup_hit;
  logic [DATA_W-1:0]        lookup_data;
  logic [ADDR_W-1:0]        lookup_addr;
  // Host table write: entry = {valid, code, payload}
  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic [CODE_W+DATA_W:0]   wr_data;
  logic                     wr_ack;

  modport master (
    output lookup_req, lookup_code, wr_req, wr_addr, wr_data,
    input  lookup_ready, lookup_done, lookup_hit, lookup_data, lookup_addr, wr_ack
  );

  modport slave (
    input  lookup_req, lookup_code, wr_req, wr_addr, wr_data,
    output lookup_ready, lookup_done, lookup_hit, lookup_data, lookup_addr, wr_ack
  );
endinterface

// File: rtl/stock_code_lookup.sv
// ---------------------------------------------------------------------------
// stock_code_lookup
// Hash-probe lookup engine in front of a single-port stock-code table RAM
// (entries {valid, code, payload}). A lookup hashes the code by folding it
// into ADDR_W-bit chunks XORed together, then linearly probes consecutive
// slots (wrapping at the top of the table) until it finds the code, hits an
// empty slot, or has examined MAX_PROBE slots. Host table writes share the
// same RAM port and take priority over a lookup waiting in IDLE.
//
// Ports
//   clk       : clock
//   reset     : synchronous, active-high reset
//   host      : stock_code_lookup_if.slave (lookup + host write handshakes)
//   ram_addr  : RAM address (combinational; base hash on the accept cycle)
//   ram_din   : RAM write data (host entry)
//   ram_we    : RAM write enable (high only in the WRITE cycle)
//   ram_dout  : RAM read data, one-cycle registered read, write-first
//
// Optional build macro STOCK_LOOKUP_STATS_EN adds saturating hit_cnt and
// miss_cnt counters plus max_probe_seen (largest number of slots examined by
// any lookup). Without the macro those ports do not exist.
// ---------------------------------------------------------------------------
module stock_code_lookup #(
  parameter int CODE_W    = 48,
  parameter int DATA_W    = 21,
  parameter int ADDR_W    = 9,
  parameter int MAX_PROBE = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  stock_code_lookup_if.slave        host,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [CODE_W+DATA_W:0]    ram_din,
  output logic                      ram_we,
  input  logic [CODE_W+DATA_W:0]    ram_dout
`ifdef STOCK_LOOKUP_STATS_EN
  ,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt,
  output logic [ADDR_W:0]           max_probe_seen
`endif
);

  localparam int ENTRY_W = CODE_W + DATA_W + 1;
  localparam int NFOLD   = (CODE_W + ADDR_W - 1) / ADDR_W;
  localparam int CNT_W   = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, PROBE} state_t;

  state_t              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [ADDR_W-1:0]   probe_addr_q;
  logic [CNT_W-1:0]    probe_cnt_q;
  logic                done_q;
  logic                hit_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   addr_q;

  // -------------------------------------------------------------------------
  // Folded-XOR hash of the incoming code. The code is zero-extended to a
  // whole number of ADDR_W chunks so the top partial chunk folds in as
  // zero-padded bits.
  // -------------------------------------------------------------------------
  logic [NFOLD*ADDR_W-1:0] code_pad;
  logic [ADDR_W-1:0]       base_d;

  assign code_pad = (NFOLD*ADDR_W)'(host.lookup_code);

  always_comb begin
    base_d = '0;
    for (int i = 0; i < NFOLD; i++) begin
      base_d = base_d ^ code_pad[i*ADDR_W +: ADDR_W];
    end
  end

  // -------------------------------------------------------------------------
  // Slot decode: ram_dout always holds the slot at probe_addr_q while in
  // PROBE, because the address for the next slot was presented last cycle.
  // -------------------------------------------------------------------------
  logic                slot_valid;
  logic [CODE_W-1:0]   slot_code;
  logic [DATA_W-1:0]   slot_payload;
  logic                slot_match;
  logic                probe_last;
  logic                probe_end;

  assign slot_valid   = ram_dout[ENTRY_W-1];
  assign slot_code    = ram_dout[ENTRY_W-2:DATA_W];
  assign slot_payload = ram_dout[DATA_W-1:0];
  assign slot_match   = slot_valid && (slot_code == code_q);
  assign probe_last   = (probe_cnt_q == CNT_W'(MAX_PROBE - 1));
  // An empty slot terminates the chain: entries are only ever placed by
  // linear probing from their hash, so nothing past a hole can match.
  assign probe_end    = slot_match || !slot_valid || probe_last;

  // -------------------------------------------------------------------------
  // RAM port mux and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    ram_addr = base_d;
    unique case (state_q)
      IDLE:    ram_addr = base_d;
      WRITE:   ram_addr = host.wr_addr;
      PROBE:   ram_addr = probe_addr_q + ADDR_W'(1);  // wraps 511 -> 0
      default: ram_addr = base_d;
    endcase
  end

  assign ram_din           = host.wr_data;
  assign ram_we            = (state_q == WRITE);
  assign host.wr_ack       = (state_q == WRITE);
  // A pending host write blocks new lookups so it is never starved.
  assign host.lookup_ready = (state_q == IDLE) && !host.wr_req;

  assign host.lookup_done  = done_q;
  assign host.lookup_hit   = hit_q;
  assign host.lookup_data  = data_q;
  assign host.lookup_addr  = addr_q;

  // -------------------------------------------------------------------------
  // Control FSM with registered results
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      code_q       <= '0;
      probe_addr_q <= '0;
      probe_cnt_q  <= '0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (host.wr_req) begin
            state_q <= WRITE;
          end else if (host.lookup_req) begin
            code_q       <= host.lookup_code;
            probe_addr_q <= base_d;
            probe_cnt_q  <= '0;
            state_q      <= PROBE;
          end
        end
        WRITE: begin
          state_q <= IDLE;
        end
        PROBE: begin
          if (probe_end) begin
            done_q  <= 1'b1;
            hit_q   <= slot_match;
            data_q  <= slot_match ? slot_payload : '0;
            addr_q  <= probe_addr_q;
            state_q <= IDLE;
          end else begin
            probe_addr_q <= probe_addr_q + ADDR_W'(1);
            probe_cnt_q  <= probe_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STOCK_LOOKUP_STATS_EN
  // -------------------------------------------------------------------------
  // Lookup statistics: saturating counters, updated on the terminating
  // compare (the same cycle the result registers load).
  // -------------------------------------------------------------------------
  logic [31:0]    hit_cnt_q;
  logic [31:0]    miss_cnt_q;
  logic [CNT_W-1:0] max_probe_q;
  logic [CNT_W-1:0] probes_used;
  logic           term;

  assign term        = (state_q == PROBE) && probe_end;
  assign probes_used = probe_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      max_probe_q <= '0;
    end else if (term) begin
      if (slot_match) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (probes_used > max_probe_q) max_probe_q <= probes_used;
    end
  end

  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;
  assign max_probe_seen = max_probe_q;
`endif

endmodule

// File: tb/tb_stock_code_lookup.sv
// ---------------------------------------------------------------------------
// tb_stock_code_lookup
// Directed bench for stock_code_lookup with a behavioural write-first RAM.
// Lookup tasks push the hand-computed expected result into a scoreboard
// queue; an independent monitor pops and compares on every lookup_done.
// ---------------------------------------------------------------------------
module tb_stock_code_lookup;

  localparam int CODE_W  = 48;
  localparam int DATA_W  = 21;
  localparam int ADDR_W  = 9;
  localparam int ENTRY_W = CODE_W + DATA_W + 1;

  logic                clk;
  logic                reset;
  logic [ADDR_W-1:0]   ram_addr;
  logic [ENTRY_W-1:0]  ram_din;
  logic                ram_we;
  logic [ENTRY_W-1:0]  ram_dout;
`ifdef STOCK_LOOKUP_STATS_EN
  logic [31:0]         hit_cnt;
  logic [31:0]         miss_cnt;
  logic [ADDR_W:0]     max_probe_seen;
`endif

  stock_code_lookup_if #(.CODE_W(CODE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  stock_code_lookup #(
    .CODE_W(CODE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PROBE(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (bus),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_we         (ram_we),
    .ram_dout       (ram_dout)
`ifdef STOCK_LOOKUP_STATS_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt),
    .max_probe_seen (max_probe_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first single-port RAM with registered read
  logic [ENTRY_W-1:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout      <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    int                lat;
    int                acc;
  } exp_t;

  exp_t              sb_q[$];
  logic              last_hit  = 1'b0;
  logic [DATA_W-1:0] last_data = '0;
  logic [ADDR_W-1:0] last_addr = '0;

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && bus.lookup_done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no result pending", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("lookup_hit",  bus.lookup_hit,  e.hit);
        check("lookup_data", bus.lookup_data, e.data);
        check("lookup_addr", bus.lookup_addr, e.addr);
        check("latency",     cyc - e.acc,     e.lat);
        last_hit  = e.hit;
        last_data = e.data;
        last_addr = e.addr;
        $display("lookup done cyc=%0d hit=%0b data=%h addr=%0d latency=%0d",
                 cyc, bus.lookup_hit, bus.lookup_data, bus.lookup_addr, cyc - e.acc);
      end
    end
  end

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [ENTRY_W-1:0] d,
                            output int ack_cyc);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wr_ack && n < 50);
    check("wr_ack_seen", bus.wr_ack, 1'b1);
    check("ram_we_with_ack", ram_we, 1'b1);
    ack_cyc = cyc;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("wr_ack_one_cycle", bus.wr_ack, 1'b0);
    $display("write addr=%0d entry=%h ack_cyc=%0d", a, d, ack_cyc);
  endtask

  task automatic lookup(input logic [CODE_W-1:0] code, input bit push, input logic hit,
                        input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] addr,
                        input int lat, output int acc);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    bus.lookup_req  = 1'b1;
    bus.lookup_code = code;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.lookup_ready && n < 50);
    check("lookup_ready_seen", bus.lookup_ready, 1'b1);
    acc = cyc;
    if (push) begin
      e.hit = hit; e.data = data; e.addr = addr; e.lat = lat; e.acc = acc;
      sb_q.push_back(e);
    end
    $display("lookup issue code=%h acc_cyc=%0d", code, acc);
    @(posedge clk); #1;
    bus.lookup_req = 1'b0;
    @(negedge clk);
    check("ready_low_in_probe", bus.lookup_ready, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  localparam logic [CODE_W-1:0] CODE_A = 48'h303030303530;  // hash 0x022

  initial begin
    int t0, t1, ack_c, acc_c;
    reset           = 1'b1;
    bus.lookup_req  = 1'b0;
    bus.lookup_code = '0;
    bus.wr_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", bus.lookup_ready, 1'b1);
    check("rst_done",  bus.lookup_done,  1'b0);
    check("rst_hit",   bus.lookup_hit,   1'b0);
    check("rst_ack",   bus.wr_ack,       1'b0);
    check("rst_we",    ram_we,           1'b0);
    check("rst_data",  bus.lookup_data,  '0);
    check("rst_addr",  bus.lookup_addr,  '0);

    // Basic write then hit on first slot
    host_write(9'd34, {1'b1, CODE_A, 21'h1ABCD}, ack_c);
    lookup(CODE_A, 1, 1'b1, 21'h1ABCD, 9'd34, 2, t0);

    // Collision: 0x040 and 0x241 both hash to 64
    host_write(9'd64, {1'b1, 48'h000000000040, 21'h00111}, ack_c);
    host_write(9'd65, {1'b1, 48'h000000000241, 21'h00222}, ack_c);
    lookup(48'h000000000241, 1, 1'b1, 21'h00222, 9'd65, 3, t0);
    lookup(48'h000000000040, 1, 1'b1, 21'h00111, 9'd64, 2, t0);

    // Chain wrap: base 511, slots 511 and 0 occupied, slot 1 empty
    host_write(9'd511, {1'b1, 48'h000000000111, 21'h00005}, ack_c);
    host_write(9'd0,   {1'b1, 48'h000000000222, 21'h00006}, ack_c);
    lookup(48'h0000000001FF, 1, 1'b0, 21'h0, 9'd1, 4, t0);

    // Max probe: slots 256..264 full of non-matching codes
    for (int i = 0; i < 9; i++)
      host_write(9'(256 + i), {1'b1, 48'h000000ABC000 + 48'(i), 21'(i + 1)}, ack_c);
    lookup(CODE_A, 1, 1'b1, 21'h1ABCD, 9'd34, 2, t0);
    lookup(48'h000000000100, 1, 1'b0, 21'h0, 9'd263, 9, t0);

    // Empty first slot
    lookup(48'h000000000080, 1, 1'b0, 21'h0, 9'd128, 2, t0);

    // Back-to-back: second accepted in the done cycle of the first
    lookup(CODE_A, 1, 1'b1, 21'h1ABCD, 9'd34, 2, t0);
    lookup(48'h000000000040, 1, 1'b1, 21'h00111, 9'd64, 2, t1);
    check("back_to_back_accept", t1 - t0, 2);

    // Write and lookup in the same IDLE cycle: write wins, lookup next cycle
    fork
      host_write(9'd300, {1'b1, 48'h00000000012C, 21'h00077}, ack_c);
      lookup(48'h00000000012C, 1, 1'b1, 21'h00077, 9'd300, 2, acc_c);
    join
    check("write_before_lookup", acc_c - ack_c, 1);
    drain();

    // Reset mid-PROBE: no done pulse, IDLE right after
    lookup(48'h000000000100, 0, 1'b0, 21'h0, 9'd0, 0, t0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", bus.lookup_ready, 1'b1);
    check("post_reset_done",  bus.lookup_done,  1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_done_after_abort", bus.lookup_done, 1'b0);
    end

    // Three hits and two misses after the reset
    lookup(CODE_A,              1, 1'b1, 21'h1ABCD, 9'd34,  2, t0);
    lookup(48'h000000000241,    1, 1'b1, 21'h00222, 9'd65,  3, t0);
    lookup(48'h00000000012C,    1, 1'b1, 21'h00077, 9'd300, 2, t0);
    lookup(48'h0000000001FF,    1, 1'b0, 21'h0,     9'd1,   4, t0);
    lookup(48'h000000000080,    1, 1'b0, 21'h0,     9'd128, 2, t0);
    drain();

    // Result registers hold until the next done
    repeat (3) @(negedge clk);
    check("hold_hit",  bus.lookup_hit,  last_hit);
    check("hold_data", bus.lookup_data, last_data);
    check("hold_addr", bus.lookup_addr, last_addr);

`ifdef STOCK_LOOKUP_STATS_EN
    check("stats_hit_cnt",   hit_cnt,        32'd3);
    check("stats_miss_cnt",  miss_cnt,       32'd2);
    check("stats_max_probe", max_probe_seen, 10'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
